encoder8to3_request: RTL

Registered 8-to-3 priority request encoder for the simple computer; it is the inverse of the 3-to-8 enable decoder. It latches one-hot or multi-hot request pulses from up to eight sources and presents the index of the highest-priority pending request as a 3-bit code. The code is held under a valid/ack handshake until the consumer accepts it. It sits in front of the control unit as the interrupt/service-request encoder.

---
 rtl/encoder8to3_request.sv | 81 ++++++++
 1 files changed

// File: rtl/encoder8to3_request.sv
// Registered 8-to-3 priority request encoder with a valid/ack handshake.
// Requests are captured into a sticky pending set and served one code at a time.
module encoder8to3_request #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       ack,
  output logic       valid,
  output logic [2:0] code,
  output logic [7:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_next;
  logic       valid_next;
  logic [2:0] code_next;
  logic [7:0] pending_next;
  logic [7:0] clr;

  // The loop direction picks the winner: the last set bit visited is kept.
  function automatic logic [2:0] priority_encode(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    if (LOW_FIRST) begin
      for (int i = 7; i >= 0; i--) if (vec[i]) idx = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    valid_next = valid;
    code_next  = code;
    clr        = 8'h00;
    case (state)
      IDLE: begin
        if (|pending) begin
          code_next  = priority_encode(pending);
          valid_next = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // Code stays frozen here regardless of newly arriving requests.
        if (ack) begin
          clr        = 8'h01 << code;
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
    endcase
    // Clear happens before set, so a same-cycle request re-arms the served bit.
    pending_next = (pending & ~clr) | (enable ? req : 8'h00);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= 1'b0;
      code    <= 3'd0;
      pending <= 8'h00;
    end else begin
      state   <= state_next;
      valid   <= valid_next;
      code    <= code_next;
      pending <= pending_next;
    end
  end

endmodule
